// File: rtl/scratch_ram_arbiter.sv
// Shares the 256x10 scratch RAM between port A (CPU) and port B (stack/irq/debug) and owns a full-RAM clear engine.
// Define SCR_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module scratch_ram_arbiter #(
    parameter int              DW      = 10,
    parameter int              AW      = 8,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          RST_N,

    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_DIN,
    output logic          A_GNT,
    output logic [DW-1:0] A_DOUT,
    output logic          A_RVALID,

    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_DIN,
    output logic          B_GNT,
    output logic [DW-1:0] B_DOUT,
    output logic          B_RVALID,

    input  logic          CLR_START,
    output logic          BUSY,

    output logic [AW-1:0] SCR_ADDR,
    output logic          SCR_WE,
    output logic [DW-1:0] SCR_DIN,
    input  logic [DW-1:0] SCR_DOUT
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] a_dout_q, a_dout_d;
    logic [DW-1:0] b_dout_q, b_dout_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic          grant_a, grant_b;

`ifdef SCR_ARB_RR_EN
    // 1 means B won the most recent grant, so A wins the next contest.
    logic          rr_last_q, rr_last_d;
`endif

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == ST_IDLE && !CLR_START) begin
`ifdef SCR_ARB_RR_EN
            grant_a = A_REQ && (!B_REQ || rr_last_q);
`else
            grant_a = A_REQ;
`endif
            grant_b = B_REQ && !grant_a;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_dout_d   = a_dout_q;
        b_dout_d   = b_dout_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
`ifdef SCR_ARB_RR_EN
        rr_last_d  = rr_last_q;
`endif
        BUSY       = 1'b0;
        SCR_WE     = 1'b0;
        SCR_ADDR   = '0;
        SCR_DIN    = '0;

        case (state_q)
            ST_CLEAR: begin
                BUSY     = 1'b1;
                SCR_WE   = 1'b1;
                SCR_ADDR = cnt_q;
                SCR_DIN  = CLR_VAL;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (CLR_START) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (grant_a) begin
                    SCR_WE   = A_WE;
                    SCR_ADDR = A_ADDR;
                    SCR_DIN  = A_DIN;
                    if (!A_WE) begin
                        a_dout_d   = SCR_DOUT;
                        a_rvalid_d = 1'b1;
                    end
`ifdef SCR_ARB_RR_EN
                    rr_last_d = 1'b0;
`endif
                end else if (grant_b) begin
                    SCR_WE   = B_WE;
                    SCR_ADDR = B_ADDR;
                    SCR_DIN  = B_DIN;
                    if (!B_WE) begin
                        b_dout_d   = SCR_DOUT;
                        b_rvalid_d = 1'b1;
                    end
`ifdef SCR_ARB_RR_EN
                    rr_last_d = 1'b1;
`endif
                end
            end
        endcase
    end

    // Reset restarts the sweep from address 0 and drops any in-flight read pulse.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
`ifdef SCR_ARB_RR_EN
            rr_last_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_dout_q   <= a_dout_d;
            b_dout_q   <= b_dout_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
`ifdef SCR_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    assign A_GNT    = grant_a;
    assign B_GNT    = grant_b;
    assign A_DOUT   = a_dout_q;
    assign B_DOUT   = b_dout_q;
    assign A_RVALID = a_rvalid_q;
    assign B_RVALID = b_rvalid_q;

endmodule

// File: tb/tb_scratch_ram_arbiter.sv
// Self-checking bench for scratch_ram_arbiter: random and directed traffic against a
// cycle-level reference of the sharing rules, with a scoreboard for read returns.
module tb_scratch_ram_arbiter;

   localparam int DW    = 10;
   localparam int AW    = 8;
   localparam int DEPTH = 256;
   localparam int CLR   = 0;

   logic          clk;
   logic          RST_N;
   logic          A_REQ, A_WE, B_REQ, B_WE;
   logic [AW-1:0] A_ADDR, B_ADDR;
   logic [DW-1:0] A_DIN, B_DIN;
   logic          A_GNT, B_GNT, A_RVALID, B_RVALID;
   logic [DW-1:0] A_DOUT, B_DOUT;
   logic          CLR_START, BUSY;
   logic [AW-1:0] SCR_ADDR;
   logic          SCR_WE;
   logic [DW-1:0] SCR_DIN, SCR_DOUT;

   scratch_ram_arbiter dut (
      .clk       (clk),
      .RST_N     (RST_N),
      .A_REQ     (A_REQ),
      .A_WE      (A_WE),
      .A_ADDR    (A_ADDR),
      .A_DIN     (A_DIN),
      .A_GNT     (A_GNT),
      .A_DOUT    (A_DOUT),
      .A_RVALID  (A_RVALID),
      .B_REQ     (B_REQ),
      .B_WE      (B_WE),
      .B_ADDR    (B_ADDR),
      .B_DIN     (B_DIN),
      .B_GNT     (B_GNT),
      .B_DOUT    (B_DOUT),
      .B_RVALID  (B_RVALID),
      .CLR_START (CLR_START),
      .BUSY      (BUSY),
      .SCR_ADDR  (SCR_ADDR),
      .SCR_WE    (SCR_WE),
      .SCR_DIN   (SCR_DIN),
      .SCR_DOUT  (SCR_DOUT)
   );

   // Behavioural RAM: writes on the rising edge, reads combinationally.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (SCR_WE) ram[SCR_ADDR] <= SCR_DIN;
   end
   assign SCR_DOUT = ram[SCR_ADDR];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index, advanced on every rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int due;
      int data;
   } exp_t;
   exp_t qa[$];
   exp_t qb[$];

   // Reference model state.
   int  m_mem [DEPTH];
   bit  m_clearing;
   int  m_clr_addr;
   bit  m_a_first;
   bit  m_known;
   bit  m_win_a, m_win_b;
   bit  mon_en;
   bit  chk_rst;
   int  busy_cnt;
   bit  a_pend, b_pend;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Raise a new request on a port unless it still holds one waiting for a grant.
   task automatic applyStimulus(input bit port_b, input bit we, input int addr, input int din);
      if (!port_b) begin
         if (!a_pend) begin
            a_pend = 1'b1;
            A_REQ  = 1'b1;
            A_WE   = we;
            A_ADDR = addr[AW-1:0];
            A_DIN  = din[DW-1:0];
         end
      end else begin
         if (!b_pend) begin
            b_pend = 1'b1;
            B_REQ  = 1'b1;
            B_WE   = we;
            B_ADDR = addr[AW-1:0];
            B_DIN  = din[DW-1:0];
         end
      end
   endtask

   // Predict this cycle's outputs from the sharing rules, compare, then apply the edge.
   task automatic modelStep();
      bit e_busy, e_ag, e_bg, e_we;
      int e_addr, e_din;
      exp_t ent;
      e_busy = 0; e_ag = 0; e_bg = 0; e_we = 0; e_addr = 0; e_din = 0;
      m_win_a = 0;
      m_win_b = 0;
      if (m_clearing) begin
         e_busy = 1;
         e_we   = 1;
         e_addr = m_clr_addr;
         e_din  = CLR;
      end else if (!CLR_START) begin
         if (A_REQ && B_REQ) begin
`ifdef SCR_ARB_RR_EN
            m_win_a = m_a_first;
`else
            m_win_a = 1;
`endif
            m_win_b = !m_win_a;
         end else begin
            m_win_a = A_REQ;
            m_win_b = B_REQ;
         end
         if (m_win_a) begin
            e_ag = 1; e_we = A_WE; e_addr = int'(A_ADDR); e_din = int'(A_DIN);
         end else if (m_win_b) begin
            e_bg = 1; e_we = B_WE; e_addr = int'(B_ADDR); e_din = int'(B_DIN);
         end
      end

      if (m_known) begin
         checkOutput("busy",     int'(BUSY),     int'(e_busy));
         checkOutput("a_gnt",    int'(A_GNT),    int'(e_ag));
         checkOutput("b_gnt",    int'(B_GNT),    int'(e_bg));
         checkOutput("scr_we",   int'(SCR_WE),   int'(e_we));
         checkOutput("scr_addr", int'(SCR_ADDR), e_addr);
         checkOutput("scr_din",  int'(SCR_DIN),  e_din);
         busy_cnt += int'(BUSY);
      end
      if (chk_rst) begin
         checkOutput("a_dout_reset", int'(A_DOUT), 0);
         checkOutput("b_dout_reset", int'(B_DOUT), 0);
         chk_rst = 0;
      end

      if (RST_N && (e_ag || e_bg) && !e_we) begin
         ent.due  = cyc + 1;
         ent.data = m_mem[e_addr];
         if (e_ag) qa.push_back(ent);
         else      qb.push_back(ent);
      end
      if (e_we) m_mem[e_addr] = e_din;

      if (!RST_N) begin
         m_clearing = 1;
         m_clr_addr = 0;
         m_a_first  = 1;
         m_known    = 1;
      end else if (m_clearing) begin
         m_clr_addr++;
         if (m_clr_addr == DEPTH) begin
            m_clearing = 0;
            m_clr_addr = 0;
         end
      end else if (CLR_START) begin
         m_clearing = 1;
         m_clr_addr = 0;
      end else if (m_win_a) begin
         m_a_first = 0;
      end else if (m_win_b) begin
         m_a_first = 1;
      end
   endtask

   task automatic runCycle();
      @(negedge clk);
      modelStep();
      @(posedge clk);
      #1;
      if (m_win_a) begin a_pend = 0; A_REQ = 0; end
      if (m_win_b) begin b_pend = 0; B_REQ = 0; end
      CLR_START = 0;
      if (m_known) mon_en = 1;
   endtask

   task automatic runSweep(input string name);
      for (int i = 0; i < 300 && m_clearing; i++) runCycle();
      checkOutput(name, busy_cnt, DEPTH);
   endtask

   // Monitor: every cycle, a read return must appear exactly when one is due.
   initial begin
      bit exp_v;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            exp_v = 0;
            if (qa.size() > 0) exp_v = (qa[0].due == cyc);
            checkOutput("a_rvalid", int'(A_RVALID), int'(exp_v));
            if (exp_v) begin
               checkOutput("a_dout", int'(A_DOUT), qa[0].data);
               void'(qa.pop_front());
            end
            exp_v = 0;
            if (qb.size() > 0) exp_v = (qb[0].due == cyc);
            checkOutput("b_rvalid", int'(B_RVALID), int'(exp_v));
            if (exp_v) begin
               checkOutput("b_dout", int'(B_DOUT), qb[0].data);
               void'(qb.pop_front());
            end
         end
      end
   end

   initial begin
      RST_N = 0; CLR_START = 0;
      A_REQ = 0; A_WE = 0; A_ADDR = '0; A_DIN = '0;
      B_REQ = 0; B_WE = 0; B_ADDR = '0; B_DIN = '0;
      m_clearing = 1; m_clr_addr = 0; m_a_first = 1; m_known = 0;
      mon_en = 0; chk_rst = 0; busy_cnt = 0; a_pend = 0; b_pend = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 'h3FF;

      repeat (3) runCycle();
      RST_N = 1;
      chk_rst = 1;
      busy_cnt = 0;
      runSweep("power_on_clear_cycles");
      runCycle();

      // Write then read back on port A.
      applyStimulus(0, 1, 'h10, 'h3A5);
      runCycle();
      applyStimulus(0, 0, 'h10, 0);
      runCycle();
      runCycle();

      // Both ports hold read requests for four cycles.
      applyStimulus(1, 1, 'h11, 'h155);
      runCycle();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 'h10, 0);
         applyStimulus(1, 0, 'h11, 0);
         runCycle();
      end
      runCycle();
      runCycle();

      // Clear command arriving together with a write request.
      applyStimulus(0, 1, 5, 'h1FF);
      CLR_START = 1;
      runCycle();
      busy_cnt = 0;
      runSweep("cmd_clear_cycles");
      runCycle();
      applyStimulus(1, 0, 5, 0);
      runCycle();
      runCycle();

      // Reset while a read return is showing and another read is being granted.
      applyStimulus(1, 0, 5, 0);
      runCycle();
      applyStimulus(1, 0, 'h10, 0);
      RST_N = 0;
      runCycle();
      RST_N = 1;
      for (int i = 0; i < 300 && m_clr_addr != 100; i++) runCycle();
      RST_N = 0;
      runCycle();
      RST_N = 1;
      busy_cnt = 0;
      runSweep("restart_clear_cycles");

      // Random traffic with occasional clear commands.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 0)
            applyStimulus(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)));
         if ($urandom_range(0, 1) == 0)
            applyStimulus(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)));
         if ($urandom_range(0, 599) == 0) CLR_START = 1;
         runCycle();
      end

      for (int i = 0; i < 300 && (a_pend || b_pend || m_clearing); i++) runCycle();
      runCycle();
      runCycle();
      checkOutput("a_pending_drained", a_pend ? 1 : 0, 0);
      checkOutput("b_pending_drained", b_pend ? 1 : 0, 0);
      checkOutput("a_returns_outstanding", qa.size(), 0);
      checkOutput("b_returns_outstanding", qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
